// File: rtl/vga_bitmap_reader.sv
// 16x16 bitmap window on VESA 800x600@60 timing, 40 MHz pixel clock.
// Two-stage read pipeline keeps sync and colour aligned at the pins.
module vga_bitmap_reader #(
  parameter int unsigned X0         = 384,
  parameter int unsigned Y0         = 284,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter logic [2:0]  FG_RGB     = 3'b111,
  parameter logic [2:0]  BG_RGB     = 3'b000
) (
  input  logic        CLK_40Mhz,
  input  logic        RSTn,
  input  logic        Write_En_Sig,
  input  logic [3:0]  Write_Addr_Sig,
  input  logic [15:0] Write_Data,
  output logic        HSYNC_Sig,
  output logic        VSYNC_Sig,
  output logic        Red_Sig,
  output logic        Green_Sig,
  output logic        Blue_Sig,
  output logic        Frame_Start
);

  localparam int unsigned H_TOTAL = 1056;
  localparam int unsigned H_VIS   = 800;
  localparam int unsigned HS_BEG  = 840;
  localparam int unsigned HS_END  = 968;
  localparam int unsigned V_TOTAL = 628;
  localparam int unsigned V_VIS   = 600;
  localparam int unsigned VS_BEG  = 601;
  localparam int unsigned VS_END  = 605;
  localparam int unsigned WIN     = 16 << SCALE_LOG2;

  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic [15:0] ram [16];

  always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
    if (!RSTn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == 11'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else if (Write_En_Sig) begin
      ram[Write_Addr_Sig] <= Write_Data;
    end
  end

  logic        visible;
  logic        in_win;
  logic        hsync_c;
  logic        vsync_c;
  logic        first_c;
  logic [10:0] hoff;
  logic [9:0]  voff;
  logic [3:0]  col;
  logic [3:0]  row;

  always_comb begin
    visible = (hcnt < 11'(H_VIS)) && (vcnt < 10'(V_VIS));
    in_win  = visible
           && (hcnt >= 11'(X0)) && (hcnt < 11'(X0 + WIN))
           && (vcnt >= 10'(Y0)) && (vcnt < 10'(Y0 + WIN));
    hsync_c = (hcnt >= 11'(HS_BEG)) && (hcnt < 11'(HS_END));
    vsync_c = (vcnt >= 10'(VS_BEG)) && (vcnt < 10'(VS_END));
    first_c = (hcnt == '0) && (vcnt == '0);
    hoff    = hcnt - 11'(X0);
    voff    = vcnt - 10'(Y0);
    col     = 4'(hoff >> SCALE_LOG2);
    row     = 4'(voff >> SCALE_LOG2);
  end

  // Stage 1: the RAM read sees pre-write data on a same-edge collision.
  logic [15:0] rd_q;
  logic        win_q;
  logic        vis_q;
  logic [3:0]  col_q;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;

  always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
    if (!RSTn) begin
      rd_q  <= '0;
      win_q <= 1'b0;
      vis_q <= 1'b0;
      col_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      rd_q  <= ram[row];
      win_q <= in_win;
      vis_q <= visible;
      col_q <= col;
      hs_q  <= hsync_c;
      vs_q  <= vsync_c;
      fs_q  <= first_c;
    end
  end

  logic       pix_bit;
  logic [2:0] rgb_next;

  always_comb begin
    pix_bit  = rd_q[4'd15 - col_q];
    rgb_next = 3'b000;
    if (vis_q) rgb_next = (win_q && pix_bit) ? FG_RGB : BG_RGB;
  end

  always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
    if (!RSTn) begin
      HSYNC_Sig   <= 1'b0;
      VSYNC_Sig   <= 1'b0;
      Red_Sig     <= 1'b0;
      Green_Sig   <= 1'b0;
      Blue_Sig    <= 1'b0;
      Frame_Start <= 1'b0;
    end else begin
      HSYNC_Sig   <= hs_q;
      VSYNC_Sig   <= vs_q;
      Red_Sig     <= rgb_next[2];
      Green_Sig   <= rgb_next[1];
      Blue_Sig    <= rgb_next[0];
      Frame_Start <= fs_q;
    end
  end

endmodule

// File: tb/tb_vga_bitmap_reader.sv
// Bench for vga_bitmap_reader: arithmetic pixel model, per-cycle compare,
// plus literal pixel/sync checks. Window placed near the top to keep runs short.
module tb_vga_bitmap_reader;

  localparam int unsigned X0 = 384;
  localparam int unsigned Y0 = 4;
  localparam int unsigned S  = 1;
  localparam logic [2:0]  FG = 3'b111;
  localparam logic [2:0]  BG = 3'b010;
  localparam int L   = 1056;
  localparam int SC  = 1 << S;
  localparam int WIN = 16 * SC;

  logic        clk = 1'b0;
  logic        RSTn;
  logic        we;
  logic [3:0]  addr;
  logic [15:0] data;
  logic        hs, vs, r, g, b, fs;

  vga_bitmap_reader #(
    .X0(X0), .Y0(Y0), .SCALE_LOG2(S), .FG_RGB(FG), .BG_RGB(BG)
  ) dut (
    .CLK_40Mhz(clk),
    .RSTn(RSTn),
    .Write_En_Sig(we),
    .Write_Addr_Sig(addr),
    .Write_Data(data),
    .HSYNC_Sig(hs),
    .VSYNC_Sig(vs),
    .Red_Sig(r),
    .Green_Sig(g),
    .Blue_Sig(b),
    .Frame_Start(fs)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [5:0] outs;
  assign outs = {hs, vs, fs, r, g, b};

  // Model: {hsync, vsync, frame_start, rgb} for a counter position.
  logic [15:0] mram [16];
  logic [5:0]  exp1, exp2;
  int          cnt;

  function automatic logic [5:0] exp_of(int pos);
    int h, v;
    logic vis, inwin, bitv, hsv, vsv, fsv;
    logic [2:0] rgb;
    h     = pos % L;
    v     = (pos / L) % 628;
    vis   = (h < 800) && (v < 600);
    inwin = vis && h >= X0 && h < X0 + WIN && v >= Y0 && v < Y0 + WIN;
    bitv  = 1'b0;
    if (inwin) bitv = mram[(v - Y0) / SC][15 - (h - X0) / SC];
    rgb   = !vis ? 3'b000 : (inwin && bitv) ? FG : BG;
    hsv   = (h >= 840) && (h < 968);
    vsv   = (v >= 601) && (v < 605);
    fsv   = (h == 0) && (v == 0);
    return {hsv, vsv, fsv, rgb};
  endfunction

  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 16; i++) mram[i] <= '0;
      exp1 <= '0;
      exp2 <= '0;
      cnt  <= 0;
    end else begin
      exp1 <= exp_of(cnt);
      exp2 <= exp1;
      cnt  <= cnt + 1;
      if (we) mram[addr] <= data;
    end
  end

  bit run = 1'b0;

  always @(negedge clk) begin
    if (run) begin
      n_chk++;
      if (outs !== exp2) begin
        n_fail++;
        if (n_fail < 30)
          $display("FAIL cycle_cmp cnt=%0d got=%b exp=%b", cnt, outs, exp2);
      end
    end
  end

  task automatic chk(string nm, logic [5:0] got, logic [5:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cnt=%0d got=%b exp=%b", nm, cnt, got, exp);
    end
  endtask

  task automatic pix(int n, logic [2:0] e, string nm);
    if (cnt == n) chk(nm, {3'b0, r, g, b}, {3'b0, e});
  endtask

  task automatic sync_lits();
    if (cnt == 1)   chk("fs_n1", {5'b0, fs}, 6'd0);
    if (cnt == 2)   chk("fs_n2", {5'b0, fs}, 6'd1);
    if (cnt == 3)   chk("fs_n3", {5'b0, fs}, 6'd0);
    if (cnt == 841) chk("hs_841", {5'b0, hs}, 6'd0);
    if (cnt == 842) chk("hs_842", {5'b0, hs}, 6'd1);
    if (cnt == 969) chk("hs_969", {5'b0, hs}, 6'd1);
    if (cnt == 970) chk("hs_970", {5'b0, hs}, 6'd0);
  endtask

  logic [3:0] ok_rows [12] = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8,
                               4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};

  task automatic rand_write();
    if ($urandom_range(0, 15) == 0) begin
      we   = 1'b1;
      addr = ok_rows[$urandom_range(0, 11)];
      data = 16'($urandom);
    end
  endtask

  localparam int COLL = 14 * L + 390;
  localparam int END1 = 37 * L + 852;
  localparam int END2 = 6 * L;

  initial begin
    RSTn = 1'b0;
    we   = 1'b0;
    addr = '0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 6'd0);
    run  = 1'b1;
    RSTn = 1'b1;
    while (cnt < END1) begin
      @(negedge clk);
      sync_lits();
      pix(4 * L + 385, BG,     "win_left_out");
      pix(4 * L + 386, FG,     "row0_c0");
      pix(4 * L + 389, FG,     "row0_c1");
      pix(4 * L + 390, BG,     "row0_c2");
      pix(4 * L + 802, 3'b000, "blank");
      pix(5 * L + 386, FG,     "row0_rep");
      pix(6 * L + 387, FG,     "row1_c0");
      pix(6 * L + 388, BG,     "row1_c1");
      pix(6 * L + 417, FG,     "row1_c15");
      pix(6 * L + 418, BG,     "win_right_out");
      pix(COLL + 2,    BG,     "coll_old");
      pix(COLL + 3,    FG,     "coll_new");
      pix(15 * L + 386, FG,    "row5_next");
      pix(34 * L + 386, FG,    "row15_c0");
      pix(34 * L + 388, BG,    "row15_c1");
      pix(35 * L + 390, FG,    "row15_c2");
      we = 1'b0;
      unique case (cnt)
        10:      begin we = 1'b1; addr = 4'd0;  data = 16'hC000; end
        11:      begin we = 1'b1; addr = 4'd1;  data = 16'h8001; end
        12:      begin we = 1'b1; addr = 4'd15; data = 16'hAAAA; end
        COLL:    begin we = 1'b1; addr = 4'd5;  data = 16'hFFFF; end
        default: rand_write();
      endcase
    end
    we = 1'b0;
    chk("pre_rst_hs", {5'b0, hs}, 6'd1);
    #2 RSTn = 1'b0;
    #1 chk("async_rst", outs, 6'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold", outs, 6'd0);
    RSTn = 1'b1;
    while (cnt < END2) begin
      @(negedge clk);
      sync_lits();
      pix(4 * L + 386, BG, "ram_cleared");
      we = 1'b0;
      rand_write();
    end
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
